// File: rtl/sensor_event_sched_pkg.sv
// sensor_pkg: shared constants, scheduler state type and clog2 helper for sensor_event_sched.
package sensor_pkg;
   localparam int RUN_LEN_DEF = 8;
   typedef enum logic {IDLE, OFFER} sched_state_t;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int k = 0; k < 31; k++) if ((1 << k) < v) r = k + 1;
      return r;
   endfunction
endpackage

// File: rtl/sensor_event_sched_if.sv
// sensor_event_sched_if: valid/ready event port carrying the line id of a detection.
interface sensor_event_sched_if #(parameter int N_CH = 4);
   import sensor_pkg::*;
   localparam int ID_W = clog2(N_CH);
   logic            evt_valid;
   logic [ID_W-1:0] evt_id;
   logic            evt_ready;
   modport master(output evt_valid, evt_id, input evt_ready);
   modport slave(input evt_valid, evt_id, output evt_ready);
endinterface

// File: rtl/sensor_event_sched_run_det.sv
// sensor_run_det: fires hit on every RUN_LEN-th consecutive zero sample of one sensor line.
module sensor_run_det import sensor_pkg::*; #(
   parameter int RUN_LEN = RUN_LEN_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic in,
   output logic hit
);
   localparam int CW = clog2(RUN_LEN);
   logic [CW-1:0] cnt;
   assign hit = enable & ~in & (cnt == CW'(RUN_LEN - 1));
   // counting restarts after each hit so long runs produce repeated detections
   always_ff @(posedge clk)
      if (reset || !enable || in || hit) cnt <= '0;
      else cnt <= cnt + 1'b1;
endmodule

// File: rtl/sensor_event_sched.sv
// sensor_event_sched: per-line run detectors feeding a round-robin scheduler onto one event port.
module sensor_event_sched import sensor_pkg::*; #(
   parameter int N_CH    = 4,
   parameter int RUN_LEN = RUN_LEN_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [N_CH-1:0]      in,
   sensor_event_sched_if.master evt,
   output logic [N_CH-1:0]      ovf,
   input  logic [N_CH-1:0]      ovf_clr
);
   localparam int ID_W = clog2(N_CH);
   logic [N_CH-1:0] hit, pend, take;
   logic [ID_W-1:0] last_grant, sel, evt_id_q;
   logic            hs, any;
   sched_state_t    state, state_n;
   genvar i;
   for (i = 0; i < N_CH; i++) begin : g_det
      sensor_run_det #(.RUN_LEN(RUN_LEN)) u_det (
         .clk(clk), .reset(reset), .enable(enable), .in(in[i]), .hit(hit[i])
      );
   end
   assign hs   = evt.evt_valid & evt.evt_ready;
   assign take = hs ? (N_CH'(1) << evt_id_q) : '0;
   assign any  = |pend;
   // scan downward so the first pending line after last_grant is the one kept
   always_comb begin
      logic [ID_W-1:0] j;
      j = '0;
      sel = '0;
      for (int k = N_CH; k >= 1; k--) begin
         j = ID_W'((int'(last_grant) + k) % N_CH);
         if (pend[j]) sel = j;
      end
   end
   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= state_n;
   always_comb
      state_n = (state == IDLE) ? (any ? OFFER : IDLE) : (hs ? IDLE : OFFER);
   always_comb begin
      evt.evt_valid = (state == OFFER);
      evt.evt_id    = evt_id_q;
   end
   // a hit on the line being consumed this cycle replaces the old event instead of overflowing
   always_ff @(posedge clk)
      if (reset) begin
         evt_id_q   <= '0;
         last_grant <= ID_W'(N_CH - 1);
         pend       <= '0;
         ovf        <= '0;
      end else begin
         if (state == IDLE && any) evt_id_q <= sel;
         if (hs) last_grant <= evt_id_q;
         pend <= hit | (pend & ~take);
         ovf  <= (ovf & ~ovf_clr) | (hit & pend & ~take);
      end
endmodule

// File: tb/tb_sensor_event_sched.sv
// tb_sensor_event_sched: scoreboard bench for sensor_event_sched with N_CH=4, RUN_LEN=8.
module tb_sensor_event_sched;
   localparam int N_CH = 4;
   localparam int RUN_LEN = 8;
   logic clk = 0;
   logic reset, enable;
   logic [N_CH-1:0] in, ovf, ovf_clr;
   int errors = 0, checks = 0, cyc = 0, hs_cnt = 0;
   int exp_q[$];
   int hs_cyc[$];
   logic prev_stall = 0, prev_hs = 0;
   logic [1:0] prev_id = 0;
   sensor_event_sched_if #(.N_CH(N_CH)) evt();
   sensor_event_sched #(.N_CH(N_CH), .RUN_LEN(RUN_LEN)) dut (
      .clk(clk), .reset(reset), .enable(enable), .in(in),
      .evt(evt), .ovf(ovf), .ovf_clr(ovf_clr)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // monitor: handshakes popped against the scoreboard, plus hold and bubble rules
   always @(negedge clk) begin : mon
      int e;
      if (reset) begin
         prev_stall = 0;
         prev_hs = 0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (evt.evt_valid !== 1'b1 || evt.evt_id !== prev_id) begin
               errors++;
               $display("FAIL hold: valid=%0b id=%0d, required valid=1 id=%0d", evt.evt_valid, evt.evt_id, prev_id);
            end
         end
         if (prev_hs) begin
            checks++;
            if (evt.evt_valid !== 1'b0) begin
               errors++;
               $display("FAIL bubble: valid=%0b after handshake, required 0", evt.evt_valid);
            end
         end
         if (evt.evt_valid === 1'b1 && evt.evt_ready === 1'b1) begin
            hs_cnt++;
            hs_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_evt: id=%0d, required no event", evt.evt_id);
            end else begin
               e = exp_q.pop_front();
               if (evt.evt_id !== 2'(e)) begin
                  errors++;
                  $display("FAIL evt_id: got %0d, required %0d", evt.evt_id, e);
               end
            end
         end
         prev_stall = (evt.evt_valid === 1'b1) && (evt.evt_ready !== 1'b1);
         prev_hs = (evt.evt_valid === 1'b1) && (evt.evt_ready === 1'b1);
         prev_id = evt.evt_id;
      end
   end
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic wait_drain(output bit ok);
      int b = 0;
      while (exp_q.size() != 0 && b < 200) begin
         tick(1);
         b++;
      end
      ok = (exp_q.size() == 0);
      tick(2);
   endtask
   task automatic test_reset();
      reset = 1; enable = 1; in = '1; ovf_clr = '0; evt.evt_ready = 0;
      tick(3);
      @(negedge clk);
      checks++;
      if (evt.evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b, required 0", evt.evt_valid); end
      checks++;
      if (evt.evt_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d, required 0", evt.evt_id); end
      checks++;
      if (ovf !== 4'b0000) begin errors++; $display("FAIL reset_ovf: got %b, required 0000", ovf); end
      @(posedge clk); #1;
      reset = 0;
      tick(2);
   endtask
   task automatic test_single_run();
      int base = hs_cnt;
      evt.evt_ready = 1;
      exp_q.push_back(2);
      in = 4'b1011;
      repeat (RUN_LEN) @(posedge clk);
      #1 in = '1;
      @(negedge clk);
      checks++;
      if (evt.evt_valid !== 1'b0) begin errors++; $display("FAIL single_early: valid=%0b one cycle after 8th zero, required 0", evt.evt_valid); end
      @(negedge clk);
      checks++;
      if (evt.evt_valid !== 1'b1 || evt.evt_id !== 2'd2) begin
         errors++; $display("FAIL single_latency: valid=%0b id=%0d, required valid=1 id=2", evt.evt_valid, evt.evt_id);
      end
      tick(10);
      checks++;
      if (hs_cnt - base != 1) begin errors++; $display("FAIL single_count: %0d events, required 1", hs_cnt - base); end
   endtask
   task automatic test_short_run();
      int base = hs_cnt;
      int n0;
      bit ok;
      evt.evt_ready = 1;
      in = 4'b1110; tick(7);
      in = 4'b1111; tick(1);
      in = 4'b1110; tick(7);
      in = 4'b1111; tick(12);
      checks++;
      if (hs_cnt != base || evt.evt_valid !== 1'b0) begin
         errors++; $display("FAIL short_run: %0d events valid=%0b, required 0 events valid=0", hs_cnt - base, evt.evt_valid);
      end
      n0 = hs_cyc.size();
      exp_q.push_back(0); exp_q.push_back(0);
      in = 4'b1110; tick(2 * RUN_LEN);
      in = 4'b1111;
      wait_drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL long_run_drain: %0d events missing, required 0", exp_q.size()); exp_q.delete(); end
      checks++;
      if (hs_cyc.size() < n0 + 2 || hs_cyc[n0+1] - hs_cyc[n0] != RUN_LEN) begin
         errors++; $display("FAIL long_run_spacing: %0d events, required 2 events %0d cycles apart", hs_cyc.size() - n0, RUN_LEN);
      end
   endtask
   task automatic test_round_robin();
      int nb;
      bit ok;
      reset = 1; tick(1); reset = 0;
      evt.evt_ready = 1;
      for (int r = 0; r < 2; r++) begin
         nb = hs_cyc.size();
         exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
         in = 4'b0100; tick(RUN_LEN);
         in = 4'b1111;
         wait_drain(ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL rr_drain burst %0d: %0d events missing, required 0", r, exp_q.size()); exp_q.delete(); end
         checks++;
         if (hs_cyc.size() < nb + 3 || hs_cyc[nb+1] - hs_cyc[nb] != 2 || hs_cyc[nb+2] - hs_cyc[nb+1] != 2) begin
            errors++; $display("FAIL rr_spacing burst %0d: %0d events, required 3 events 2 cycles apart", r, hs_cyc.size() - nb);
         end
      end
   endtask
   task automatic test_backpressure();
      int base = hs_cnt;
      bit ok;
      evt.evt_ready = 0;
      in = 4'b1101; tick(2 * RUN_LEN);
      checks++;
      if (ovf !== 4'b0010 || evt.evt_valid !== 1'b1 || evt.evt_id !== 2'd1) begin
         errors++; $display("FAIL bp_ovf_set: ovf=%b valid=%0b id=%0d, required ovf=0010 valid=1 id=1", ovf, evt.evt_valid, evt.evt_id);
      end
      tick(RUN_LEN - 1);
      ovf_clr = 4'b0010; tick(1);
      ovf_clr = '0; in = '1;
      checks++;
      if (ovf !== 4'b0010) begin errors++; $display("FAIL bp_set_wins: ovf=%b, required 0010", ovf); end
      ovf_clr = 4'b0010; tick(1);
      ovf_clr = '0;
      checks++;
      if (ovf !== 4'b0000) begin errors++; $display("FAIL bp_clear: ovf=%b, required 0000", ovf); end
      tick(5);
      exp_q.push_back(1);
      evt.evt_ready = 1;
      wait_drain(ok);
      tick(8);
      checks++;
      if (!ok || hs_cnt - base != 1) begin
         errors++; $display("FAIL bp_drain: %0d events, required 1", hs_cnt - base); exp_q.delete();
      end
   endtask
   task automatic test_enable_reset();
      int base = hs_cnt;
      bit ok;
      evt.evt_ready = 1;
      in = 4'b0111; tick(5);
      enable = 0; tick(2);
      enable = 1; tick(RUN_LEN - 1);
      in = '1; tick(6);
      checks++;
      if (hs_cnt != base || evt.evt_valid !== 1'b0) begin
         errors++; $display("FAIL enable_restart: %0d events valid=%0b, required 0 events valid=0", hs_cnt - base, evt.evt_valid);
      end
      exp_q.push_back(3);
      in = 4'b0111; tick(RUN_LEN);
      in = '1;
      wait_drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL enable_fresh_run: %0d events missing, required 0", exp_q.size()); exp_q.delete(); end
      evt.evt_ready = 0;
      in = 4'b1110; tick(RUN_LEN);
      in = '1; enable = 0; tick(3);
      checks++;
      if (evt.evt_valid !== 1'b1 || evt.evt_id !== 2'd0) begin
         errors++; $display("FAIL disabled_offer: valid=%0b id=%0d, required valid=1 id=0", evt.evt_valid, evt.evt_id);
      end
      exp_q.push_back(0);
      evt.evt_ready = 1;
      wait_drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL disabled_drain: %0d events missing, required 0", exp_q.size()); exp_q.delete(); end
      enable = 1;
      evt.evt_ready = 0;
      in = 4'b1011; tick(RUN_LEN);
      in = '1; tick(2);
      checks++;
      if (evt.evt_valid !== 1'b1 || evt.evt_id !== 2'd2) begin
         errors++; $display("FAIL pre_reset_offer: valid=%0b id=%0d, required valid=1 id=2", evt.evt_valid, evt.evt_id);
      end
      reset = 1; tick(1);
      checks++;
      if (evt.evt_valid !== 1'b0 || ovf !== 4'b0000) begin
         errors++; $display("FAIL reset_offer: valid=%0b ovf=%b, required valid=0 ovf=0000", evt.evt_valid, ovf);
      end
      reset = 0;
      evt.evt_ready = 1;
      tick(12);
      checks++;
      if (evt.evt_valid !== 1'b0) begin errors++; $display("FAIL reset_pending: valid=%0b after reset, required 0", evt.evt_valid); end
   endtask
   initial begin
      test_reset();
      test_single_run();
      test_short_run();
      test_round_robin();
      test_backpressure();
      test_enable_reset();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: %0d entries, required 0", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required finish before 200000");
      $fatal(1);
   end
endmodule
